// File: rtl/wb_busdecode_pkg.sv
// Shared types and default address map for the Wishbone bus decoder.
// Default map: slave0 @0x0000000, slave1 @0x0400000, slave2 @0x0800000, slave3 @0x3C00000.
package wb_busdecode_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } state_e;

  localparam int WB_NS = 4;
  localparam int WB_AW = 30;

  localparam logic [WB_NS*WB_AW-1:0] DEF_SLAVE_BASE =
    {30'h3C00000, 30'h0800000, 30'h0400000, 30'h0000000};
  localparam logic [WB_NS*WB_AW-1:0] DEF_SLAVE_MASK = {WB_NS{30'h3C00000}};

  localparam int DEF_TIMEOUT = 1023;

  // Width of a counter able to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts cycles spent waiting on a slave; o_expired flags the last allowed cycle.
module wb_timeout_counter
  import wb_busdecode_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic r_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_limit;

  // The cycle that would bring the count to TIMEOUT is the expiring one.
  assign at_limit  = (cnt_q == CW'(TIMEOUT - 1));
  assign o_expired = i_enable && at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && !at_limit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_busdecode.sv
// Single-master Wishbone address decoder: routes one outstanding transaction to the
// lowest-index matching slave, reporting unmapped addresses, slave errors and timeouts.
module wb_busdecode
  import wb_busdecode_pkg::*;
#(
  parameter int                 NS         = WB_NS,
  parameter int                 AW         = WB_AW,
  parameter int                 DW         = 32,
  parameter logic [NS*AW-1:0]   SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NS*AW-1:0]   SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int                 TIMEOUT    = DEF_TIMEOUT
) (
  input  logic               i_clk,
  input  logic               r_reset,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [DW-1:0]      i_wb_data,
  input  logic [DW/8-1:0]    i_wb_sel,
  output logic               o_wb_stall,
  output logic               o_wb_ack,
  output logic               o_wb_err,
  output logic [DW-1:0]      o_wb_data,
  output logic [NS-1:0]      o_s_cyc,
  output logic [NS-1:0]      o_s_stb,
  output logic               o_s_we,
  output logic [AW-1:0]      o_s_addr,
  output logic [DW-1:0]      o_s_data,
  output logic [DW/8-1:0]    o_s_sel,
  input  logic [NS-1:0]      i_s_stall,
  input  logic [NS-1:0]      i_s_ack,
  input  logic [NS-1:0]      i_s_err,
  input  logic [NS*DW-1:0]   i_s_data,
  output logic [AW-1:0]      o_err_addr,
  output logic               o_timeout
);

  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  state_e            state_q, state_d;
  logic [NS-1:0]     cyc_q, cyc_d;
  logic [NS-1:0]     stb_q, stb_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic [AW-1:0]     err_addr_q, err_addr_d;

  logic              s_we_q, s_we_d;
  logic [AW-1:0]     s_addr_q, s_addr_d;
  logic [DW-1:0]     s_data_q, s_data_d;
  logic [DW/8-1:0]   s_sel_q, s_sel_d;
  logic [DW-1:0]     wb_data_q, wb_data_d;

  logic              dec_hit;
  logic [IW-1:0]     dec_idx;
  logic [NS-1:0]     dec_oh;
  logic              tmo_expired;
  logic              in_active;

  assign in_active = (state_q == ACTIVE);

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .r_reset   (r_reset),
    .i_clear   (!in_active),
    .i_enable  (in_active),
    .o_expired (tmo_expired)
  );

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    dec_oh  = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if ((i_wb_addr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
        dec_hit = 1'b1;
        dec_idx = IW'(k);
      end
    end
    dec_oh[dec_idx] = dec_hit;
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    idx_d      = idx_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    tmo_d      = 1'b0;
    err_addr_d = err_addr_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_data_d   = s_data_q;
    s_sel_d    = s_sel_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          s_we_d   = i_wb_we;
          s_addr_d = i_wb_addr;
          s_data_d = i_wb_data;
          s_sel_d  = i_wb_sel;
          if (dec_hit) begin
            state_d = ACTIVE;
            idx_d   = dec_idx;
            cyc_d   = dec_oh;
            stb_d   = dec_oh;
          end else begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_addr_d = i_wb_addr;
          end
        end
      end

      // Abort beats error beats ack beats timeout.
      ACTIVE: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
          cyc_d   = '0;
          stb_d   = '0;
        end else if (i_s_err[idx_q]) begin
          state_d    = IDLE;
          cyc_d      = '0;
          stb_d      = '0;
          err_d      = 1'b1;
          err_addr_d = s_addr_q;
        end else if (i_s_ack[idx_q]) begin
          state_d   = IDLE;
          cyc_d     = '0;
          stb_d     = '0;
          ack_d     = 1'b1;
          wb_data_d = i_s_data[idx_q*DW +: DW];
        end else if (tmo_expired) begin
          state_d    = IDLE;
          cyc_d      = '0;
          stb_d      = '0;
          err_d      = 1'b1;
          tmo_d      = 1'b1;
          err_addr_d = s_addr_q;
        end else if (!i_s_stall[idx_q]) begin
          stb_d = '0;
        end
      end

      ERROR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        stb_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      stb_q      <= '0;
      idx_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      idx_q      <= idx_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Payload registers carry no reset; they are only meaningful alongside cyc/ack.
  always_ff @(posedge i_clk) begin
    s_we_q    <= s_we_d;
    s_addr_q  <= s_addr_d;
    s_data_q  <= s_data_d;
    s_sel_q   <= s_sel_d;
    wb_data_q <= wb_data_d;
  end

  assign o_wb_stall = (state_q != IDLE);
  assign o_wb_ack   = ack_q;
  assign o_wb_err   = err_q;
  assign o_wb_data  = wb_data_q;
  assign o_s_cyc    = cyc_q;
  assign o_s_stb    = stb_q;
  assign o_s_we     = s_we_q;
  assign o_s_addr   = s_addr_q;
  assign o_s_data   = s_data_q;
  assign o_s_sel    = s_sel_q;
  assign o_err_addr = err_addr_q;
  assign o_timeout  = tmo_q;

endmodule

// File: tb/tb_wb_busdecode.sv
// Bench for wb_busdecode: directed scenarios plus randomized transactions checked
// against an address-map and outcome model built from the decoder's rules.
module tb_wb_busdecode;

  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          r_reset;
  logic          m_cyc, m_stb, m_we;
  logic [29:0]   m_addr;
  logic [31:0]   m_data;
  logic [3:0]    m_sel;
  logic          o_wb_stall, o_wb_ack, o_wb_err;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_s_cyc, o_s_stb;
  logic          o_s_we;
  logic [29:0]   o_s_addr;
  logic [31:0]   o_s_data;
  logic [3:0]    o_s_sel;
  logic [3:0]    s_stall, s_ack, s_err;
  logic [127:0]  s_data;
  logic [29:0]   o_err_addr;
  logic          o_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_busdecode #(
    .TIMEOUT (TMO)
  ) dut (
    .i_clk      (clk),
    .r_reset    (r_reset),
    .i_wb_cyc   (m_cyc),
    .i_wb_stb   (m_stb),
    .i_wb_we    (m_we),
    .i_wb_addr  (m_addr),
    .i_wb_data  (m_data),
    .i_wb_sel   (m_sel),
    .o_wb_stall (o_wb_stall),
    .o_wb_ack   (o_wb_ack),
    .o_wb_err   (o_wb_err),
    .o_wb_data  (o_wb_data),
    .o_s_cyc    (o_s_cyc),
    .o_s_stb    (o_s_stb),
    .o_s_we     (o_s_we),
    .o_s_addr   (o_s_addr),
    .o_s_data   (o_s_data),
    .o_s_sel    (o_s_sel),
    .i_s_stall  (s_stall),
    .i_s_ack    (s_ack),
    .i_s_err    (s_err),
    .i_s_data   (s_data),
    .o_err_addr (o_err_addr),
    .o_timeout  (o_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address map: region code in bits [25:22]; codes 0,1,2 -> slaves 0..2, 15 -> slave 3.
  function automatic int region_of(input logic [29:0] a);
    case (a[25:22])
      4'd0:    return 0;
      4'd1:    return 1;
      4'd2:    return 2;
      4'd15:   return 3;
      default: return -1;
    endcase
  endfunction

  // Drive slave-side inputs; unselected slaves get random stray acks/errs/stalls.
  task automatic drive_slaves(input int k, input bit do_ack, input bit do_err,
                              input logic [31:0] d, input bit stall);
    logic [3:0] oh;
    oh      = (k >= 0) ? 4'(1 << k) : 4'b0;
    s_ack   = 4'($urandom) & 4'($urandom) & 4'($urandom) & ~oh;
    s_err   = 4'($urandom) & 4'($urandom) & 4'($urandom) & ~oh;
    s_stall = 4'($urandom) & ~oh;
    s_data  = {$urandom, $urandom, $urandom, $urandom};
    if (k >= 0) begin
      s_ack[k]          = do_ack;
      s_err[k]          = do_err;
      s_stall[k]        = stall;
      s_data[k*32 +: 32] = d;
    end
  endtask

  // kind: 0 ack, 1 err, 2 no response, 3 ack+err together. drop_at 0 = never drop cyc.
  task automatic run_txn(input logic [29:0] addr, input logic we, input int stall_n,
                         input int resp_at, input int kind, input int drop_at,
                         input logic [31:0] rdata);
    int         k, e, outc;
    logic [31:0] wdata;
    logic [3:0]  sel, oh;
    k     = region_of(addr);
    wdata = $urandom;
    sel   = 4'($urandom);
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_addr = addr; m_data = wdata; m_sel = sel;
    drive_slaves(k, 1'b0, 1'b0, 32'h0, stall_n > 0);
    if (k < 0) begin
      @(posedge clk); #1;
      chk("unmap_err", 64'(o_wb_err), 64'd1);
      chk("unmap_ack", 64'(o_wb_ack), 64'd0);
      chk("unmap_cyc", 64'(o_s_cyc), 64'd0);
      chk("unmap_stall", 64'(o_wb_stall), 64'd1);
      chk("unmap_tmo", 64'(o_timeout), 64'd0);
      chk("unmap_erraddr", 64'(o_err_addr), 64'(addr));
      m_cyc = 1'b0; m_stb = 1'b0;
      drive_slaves(-1, 1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      chk("unmap_err_once", 64'(o_wb_err), 64'd0);
      chk("unmap_idle_stall", 64'(o_wb_stall), 64'd0);
      return;
    end
    oh   = 4'(1 << k);
    e    = TMO;
    outc = 2;
    if (kind != 2 && resp_at <= TMO) begin
      e    = resp_at;
      outc = (kind == 3) ? 1 : kind;
    end
    if (drop_at > 0 && drop_at < e) begin
      e    = drop_at;
      outc = 3;
    end
    for (int n = 1; n <= e + 3; n++) begin
      @(posedge clk); #1;
      if (n <= e) begin
        chk("act_cyc", 64'(o_s_cyc), 64'(oh));
        chk("act_stb", 64'(o_s_stb), 64'((n <= stall_n + 1) ? oh : 4'b0));
        chk("act_stall", 64'(o_wb_stall), 64'd1);
        chk("act_ack", 64'(o_wb_ack), 64'd0);
        chk("act_err", 64'(o_wb_err), 64'd0);
        if (n == 1) begin
          chk("s_addr", 64'(o_s_addr), 64'(addr));
          chk("s_we", 64'(o_s_we), 64'(we));
          chk("s_data", 64'(o_s_data), 64'(wdata));
          chk("s_sel", 64'(o_s_sel), 64'(sel));
          m_stb = 1'b0;
        end
      end else if (n == e + 1) begin
        chk("end_cyc", 64'(o_s_cyc), 64'd0);
        chk("end_stb", 64'(o_s_stb), 64'd0);
        chk("end_stall", 64'(o_wb_stall), 64'd0);
        chk("end_ack", 64'(o_wb_ack), 64'(outc == 0));
        chk("end_err", 64'(o_wb_err), 64'(outc == 1 || outc == 2));
        chk("end_tmo", 64'(o_timeout), 64'(outc == 2));
        if (outc == 0) chk("end_rdata", 64'(o_wb_data), 64'(rdata));
        if (outc == 1 || outc == 2) chk("end_erraddr", 64'(o_err_addr), 64'(addr));
      end else begin
        chk("post_ack", 64'(o_wb_ack), 64'd0);
        chk("post_err", 64'(o_wb_err), 64'd0);
        chk("post_cyc", 64'(o_s_cyc), 64'd0);
      end
      if (n == drop_at || n > e) m_cyc = 1'b0;
      drive_slaves(k, (kind == 0 || kind == 3) && n == resp_at,
                   (kind == 1 || kind == 3) && n == resp_at, rdata, n <= stall_n);
    end
    drive_slaves(-1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    r_reset = 1'b1;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0; m_sel = '0;
    s_stall = '0; s_ack = '0; s_err = '0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 64'(o_s_cyc), 64'd0);
    chk("rst_stb", 64'(o_s_stb), 64'd0);
    chk("rst_ack", 64'(o_wb_ack), 64'd0);
    chk("rst_err", 64'(o_wb_err), 64'd0);
    chk("rst_tmo", 64'(o_timeout), 64'd0);
    chk("rst_stall", 64'(o_wb_stall), 64'd0);
    chk("rst_erraddr", 64'(o_err_addr), 64'd0);
    r_reset = 1'b0;

    // Stalled read from slave 1 returning DEADBEEF.
    run_txn(30'h0400010, 1'b0, 2, 5, 0, 0, 32'hDEADBEEF);
    // Unmapped write.
    run_txn(30'h1000000, 1'b1, 0, 0, 2, 0, 32'h0);
    // Slave 0 never answers, then a normal read.
    run_txn(30'h0000040, 1'b0, 0, 0, 2, 0, 32'h0);
    run_txn(30'h0000044, 1'b0, 1, 3, 0, 0, 32'h12345678);
    // Master aborts two cycles in; slave acks late.
    run_txn(30'h0800008, 1'b0, 0, 4, 0, 2, 32'h55AA55AA);
    // Ack coincident with timeout on slave 2.
    run_txn(30'h0800100, 1'b0, 0, TMO, 0, 0, 32'hA5A5F00D);
    // Error coincident with timeout, error from slave 3, ack+err together.
    run_txn(30'h0400200, 1'b1, 0, TMO, 1, 0, 32'h0);
    run_txn(30'h3C00ABC, 1'b1, 1, 2, 1, 0, 32'h0);
    run_txn(30'h0000300, 1'b0, 0, 1, 3, 0, 32'h0BADCAFE);

    // Reset during a slave-3 transaction, then a stray ack from slave 3.
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_addr = 30'h3C00123;
    drive_slaves(3, 1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("rstmid_cyc", 64'(o_s_cyc), 64'h8);
    m_stb = 1'b0; r_reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_cyc0", 64'(o_s_cyc), 64'd0);
    chk("rstmid_stb0", 64'(o_s_stb), 64'd0);
    chk("rstmid_ack", 64'(o_wb_ack), 64'd0);
    chk("rstmid_err", 64'(o_wb_err), 64'd0);
    chk("rstmid_tmo", 64'(o_timeout), 64'd0);
    chk("rstmid_stall", 64'(o_wb_stall), 64'd0);
    chk("rstmid_erraddr", 64'(o_err_addr), 64'd0);
    r_reset = 1'b0; m_cyc = 1'b0;
    drive_slaves(3, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0);
    @(posedge clk); #1;
    chk("rstmid_late_ack", 64'(o_wb_ack), 64'd0);
    chk("rstmid_late_err", 64'(o_wb_err), 64'd0);
    chk("rstmid_late_cyc", 64'(o_s_cyc), 64'd0);
    drive_slaves(-1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized transactions across all regions and outcomes.
    for (int t = 0; t < 30; t++) begin
      logic [29:0] a;
      logic [3:0]  code;
      int          r, st, ra, kd, dr;
      r = int'($urandom_range(0, 5));
      case (r)
        0: code = 4'd0;
        1: code = 4'd1;
        2: code = 4'd2;
        3: code = 4'd15;
        default: code = 4'($urandom_range(3, 14));
      endcase
      a        = 30'($urandom);
      a[25:22] = code;
      st = int'($urandom_range(0, 3));
      ra = int'($urandom_range(1, 18));
      kd = int'($urandom_range(0, 3));
      dr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      if (dr == ra) dr = 0;
      run_txn(a, 1'($urandom), st, ra, kd, dr, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
